// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Owns the PC and issues instruction-memory reads with at most one request
// outstanding. A fetched instruction sits in a one-entry output buffer until
// decode accepts it. A taken branch resolved in decode redirects the PC,
// clears the buffer, pulses flush_o, and drops any in-flight response.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   stall_i           decode does not accept this cycle
//   br_taken_i        redirect pulse from the branch-condition checker
//   br_target_i       redirect target (low two bits ignored)
//   imem_req_o/addr_o read request and word-aligned address
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     read data valid (in order, >= 1 cycle after gnt)
//   imem_rdata_i      read data
//   if_valid_o        output buffer holds an instruction
//   if_pc_o/instr_o   PC and instruction of the buffered entry
//   flush_o           kill the IF/ID register this cycle
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               br_taken_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               flush_o
);

  // FETCH: may issue. WAIT: response pending, will be buffered.
  // DROP: response pending but stale after a redirect, will be discarded.
  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetchState_t;

  fetchState_t        state, stateNext;
  logic [ADDR_W-1:0]  pc, pendPc;
  logic               bufValid;
  logic [ADDR_W-1:0]  bufPc;
  logic [INSTR_W-1:0] bufInstr;
  logic               accept, issue;
  logic [ADDR_W-1:0]  pcTarget;

  assign accept   = bufValid & ~stall_i;
  assign issue    = imem_req_o & imem_gnt_i;
  // Word-align the redirect target.
  assign pcTarget = br_target_i & ~ADDR_W'(3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= stateNext;
  end

  // Next state; a redirect on an issue or on a pending WAIT turns the
  // in-flight response into one to discard.
  always_comb begin
    stateNext = state;
    unique case (state)
      FETCH: if (issue)              stateNext = br_taken_i ? DROP : WAIT;
      WAIT:  if (imem_rvalid_i)      stateNext = FETCH;
             else if (br_taken_i)    stateNext = DROP;
      DROP:  if (imem_rvalid_i)      stateNext = FETCH;
      default:                       stateNext = FETCH;
    endcase
  end

  // Outputs. Issue only when the buffer will be free at the next edge, so a
  // response can always be stored when it returns. Held quiet during reset.
  always_comb begin
    imem_req_o = ~rst & (state == FETCH) & (~bufValid | accept);
    flush_o    = ~rst & br_taken_i;
  end

  assign imem_addr_o = pc;
  assign if_valid_o  = bufValid;
  assign if_pc_o     = bufPc;
  assign if_instr_o  = bufInstr;

  // PC, pending-request PC and output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      pendPc   <= '0;
      bufValid <= 1'b0;
      bufPc    <= '0;
      bufInstr <= '0;
    end else begin
      if (br_taken_i) pc <= pcTarget;
      else if (issue) pc <= pc + ADDR_W'(4);

      if (issue) pendPc <= pc;

      // Redirect wins over a returning response and over stall.
      if (br_taken_i) begin
        bufValid <= 1'b0;
      end else if (state == WAIT && imem_rvalid_i) begin
        bufValid <= 1'b1;
        bufPc    <= pendPc;
        bufInstr <= imem_rdata_i;
      end else if (accept) begin
        bufValid <= 1'b0;
      end
    end
  end

endmodule
